pkt_capture_buf: RTL
====================

# pkt_capture_buf

Parametrised packet capture buffer for the capture datapath. It writes an incoming word stream sequentially into an internal dual-port RAM of 2^AW words × DW bits. A packet closes on an explicit last marker or when the buffer fills, and is then held for random-access readout until the consumer acknowledges it. A circular mode (WRAP=1) keeps the most recent DEPTH words instead of stopping at full.

## Interface
- DW, 8, data width in bits (≥1)
- AW, 5, address width; DEPTH = 2^AW words (AW ≥ 2)
- WRAP, 0, 0 = stop-at-full (close packet on DEPTH-th word); 1 = circular overwrite, close only on wr_last
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- wr_en  in  1  write strobe; word accepted only in FILL
- wr_data  in  DW  write word
- wr_last  in  1  qualifies wr_en: accepted word is last of packet
- pkt_ack  in  1  consumer release of held packet (single-cycle pulse)
- rd_en  in  1  read strobe
- rd_addr  in  AW  read address
- rd_data  out  DW  registered read data
- rd_valid  out  1  rd_data updated this cycle
- wr_addr  out  AW  next write address
- pkt_len  out  AW+1  words written in current packet, saturating at DEPTH
- pkt_full  out  1  pkt_len == DEPTH
- pkt_done  out  1  packet held (state HOLD)
- overflow  out  1  sticky: write attempted while in HOLD

## Operation
- Two states: FILL and HOLD. Reset state is FILL. pkt_done = (state == HOLD).
- Accepted write: wr_en=1 in FILL.
  - mem[wr_addr] <= wr_data.
  - wr_addr <= wr_addr+1 modulo DEPTH.
  - pkt_len <= min(pkt_len+1, DEPTH).
- FILL→HOLD on an accepted write when either:
  - wr_last=1, or
  - WRAP=0 and the write makes pkt_len reach DEPTH.
- WRAP=1 at full: wr_addr wraps to 0, older words are overwritten, pkt_len stays DEPTH, pkt_full stays 1, state stays FILL.
- Oldest valid word: address 0 if pkt_len < DEPTH; otherwise address wr_addr (WRAP=1 after a wrap).
- HOLD:
  - wr_en drops the word; memory, wr_addr and pkt_len are unchanged.
  - wr_en also sets overflow.
  - pkt_ack → FILL with wr_addr=0, pkt_len=0, overflow=0.
  - If pkt_ack and wr_en occur in the same cycle, ack wins: the word is dropped and overflow is not set.
- pkt_ack in FILL is ignored.
- Reads are legal in any state and independent of writes.
  - rd_en=1 → rd_data <= mem[rd_addr] and rd_valid <= 1 on the next edge.
  - rd_en=0 → rd_valid <= 0 and rd_data holds its value.
- Same-address read and write in one cycle: read-before-write, so rd_data returns the old content.
- Reset values: wr_addr=0, pkt_len=0, pkt_full=0, pkt_done=0, overflow=0, rd_data=0, rd_valid=0. Memory contents are not reset.
- Reset asserted mid-packet or in HOLD: the block returns to FILL at once and the partial packet is discarded.

## Timing
- Write: data is in RAM after the accepting edge. wr_addr, pkt_len, pkt_full and pkt_done update on that same edge.
- Read latency: 1 cycle from rd_en to rd_data/rd_valid. Fully pipelined; back-to-back reads allowed.
- A read issued on the edge after a write to the same address returns the new data.
- pkt_ack takes effect on the next edge. A write is accepted from the following cycle.
- pkt_full is combinational from the registered pkt_len: no extra latency.
- Every output is either registered or decoded only from registered state; no input-to-output combinational path.

## Test plan
- Reset then 5 writes (0x11..0x15, last on 5th), reads of addr 0..4 → pkt_done=1, pkt_len=5, wr_addr=5; rd_data 0x11..0x15 one cycle after each rd_en, rd_valid aligned.
- WRAP=0, AW=5, 32 writes without wr_last → pkt_full=1, pkt_done=1 after the 32nd edge, wr_addr=0. Then a 33rd write → overflow=1, mem[0] unchanged. Then pkt_ack → pkt_len=0, overflow=0, state FILL.
- WRAP=1, AW=5, 40 writes of value i (0..39), last on 40th → pkt_len=32, wr_addr=8, addr 8 reads 8, addr 7 reads 39.
- In HOLD, pkt_ack and wr_en in the same cycle → overflow stays 0, next-cycle write lands at addr 0 with pkt_len=1.
- Write 0xAA to addr 3 with a simultaneous read of addr 3 (old 0x55) → rd_data=0x55; re-read next cycle → 0xAA.
- rst pulsed low after 10 writes → all outputs at reset values asynchronously. Writes resume at addr 0 after release.

Source files
------------

// File: rtl/pkt_capture_buf.sv
// pkt_capture_buf
//
// Packet capture buffer. An incoming word stream is written sequentially
// into an internal dual-port RAM of 2^AW words x DW bits. A packet closes on
// an explicit last marker, or when the buffer fills if WRAP=0. The closed
// packet is then held for random-access readout until the consumer
// acknowledges it. With WRAP=1 the buffer is circular and keeps the most
// recent DEPTH words. It closes only on wr_last_i.
//
// Parameters
//   DW    data width in bits (>= 1)
//   AW    address width; DEPTH = 2^AW words (>= 2)
//   WRAP  0: close the packet on the DEPTH-th word; 1: circular overwrite
//
// Ports
//   clk         system clock; all logic is on the rising edge
//   rst         asynchronous, active-low reset
//   wr_en_i     write strobe; a word is accepted only in FILL
//   wr_data_i   write word
//   wr_last_i   qualifies wr_en_i: the accepted word is the last of the packet
//   pkt_ack_i   consumer release of the held packet (single-cycle pulse)
//   rd_en_i     read strobe
//   rd_addr_i   read address
//   rd_data_o   registered read data (1-cycle latency)
//   rd_valid_o  rd_data_o was updated this cycle
//   wr_addr_o   next write address
//   pkt_len_o   words written in the current packet, saturating at DEPTH
//   pkt_full_o  pkt_len_o == DEPTH
//   pkt_done_o  a packet is held (state HOLD)
//   overflow_o  sticky; a write was attempted while in HOLD

module pkt_capture_buf #(
  parameter int unsigned DW   = 8,
  parameter int unsigned AW   = 5,
  parameter bit          WRAP = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          wr_last_i,
  input  logic          pkt_ack_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o,
  output logic          rd_valid_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [AW:0]   pkt_len_o,
  output logic          pkt_full_o,
  output logic          pkt_done_o,
  output logic          overflow_o
);

  localparam int unsigned Depth = 1 << AW;
  localparam int unsigned LenW  = AW + 1;
  localparam logic [LenW-1:0] DepthLen = LenW'(Depth);

  typedef enum logic [0:0] {
    StFill,
    StHold
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [LenW-1:0] len_q, len_d;
  logic            ovf_q, ovf_d;
  logic [LenW-1:0] len_inc;
  logic            wr_accept;

  logic [DW-1:0]   mem_q [Depth];
  logic [DW-1:0]   rd_data_q;
  logic            rd_valid_q;

  // Next-state logic for the packet FSM and its write-side counters.
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    wr_accept = 1'b0;
    // The length saturates at DEPTH. This only matters in circular mode,
    // where writes continue past full.
    len_inc   = (len_q == DepthLen) ? len_q : len_q + LenW'(1);

    unique case (state_q)
      StFill: begin
        // pkt_ack_i is ignored here. Nothing is held, so there is nothing to release.
        if (wr_en_i) begin
          wr_accept = 1'b1;
          wr_addr_d = wr_addr_q + AW'(1);
          len_d     = len_inc;
          if (wr_last_i || (!WRAP && (len_inc == DepthLen))) begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        // The ack takes priority over a colliding write. The write is
        // dropped and is not counted as an overflow.
        if (pkt_ack_i) begin
          state_d   = StFill;
          wr_addr_d = '0;
          len_d     = '0;
          ovf_d     = 1'b0;
        end else if (wr_en_i) begin
          ovf_d = 1'b1;
        end
      end
      default: begin
        state_d = StFill;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StFill;
      wr_addr_q <= '0;
      len_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      len_q     <= len_d;
      ovf_q     <= ovf_d;
    end
  end

  // RAM write port. The storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_addr_q] <= wr_data_i;
    end
  end

  // RAM read port. Nonblocking update order gives read-before-write on a
  // same-address collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en_i;
      if (rd_en_i) begin
        rd_data_q <= mem_q[rd_addr_i];
      end
    end
  end

  // Every output comes from a register or is decoded from registered state.
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign pkt_len_o  = len_q;
  assign pkt_full_o = (len_q == DepthLen);
  assign pkt_done_o = (state_q == StHold);
  assign overflow_o = ovf_q;

endmodule
